renkon_mem_net_burst: RTL and testbench

Banked, parametrised network-parameter memory for the renkon core. The host writes single words; the core streams them back as BANKS-wide lines through a burst engine with ready/valid backpressure. It replaces the single-word, single-lane net memory with these additions:
- configurable width, depth and bank count;
- an autonomous burst address generator;
- a 2-entry output skid buffer.

---
 rtl/renkon_mem_net_pkg.sv | 30 +++
 rtl/renkon_mem_net_skid.sv | 64 ++++++
 rtl/renkon_mem_net_burst.sv | 153 +++++++++++++++
 tb/tb_renkon_mem_net_burst.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/renkon_mem_net_pkg.sv
// rtl/renkon_mem_net_pkg.sv - shared types, defaults and helpers for the banked net memory
package renkon_mem_net_pkg;

    localparam int DWIDTH_DEF  = 16;
    localparam int NETSIZE_DEF = 14;
    localparam int BANKS_DEF   = 4;

    function automatic int lb_of(input int banks);
        return $clog2(banks);
    endfunction

    function automatic int linesize_of(input int netsize, input int banks);
        return netsize - $clog2(banks);
    endfunction

    localparam int LB_DEF       = lb_of(BANKS_DEF);
    localparam int LINESIZE_DEF = linesize_of(NETSIZE_DEF, BANKS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit offset of lane k inside a packed line of w-bit words.
    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/renkon_mem_net_skid.sv
// rtl/renkon_mem_net_skid.sv - two-entry ready/valid buffer exposing its occupancy
module renkon_mem_net_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             pop;

    assign pop       = out_valid && out_ready;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign count     = count_q;

    // The head only changes on a pop or when filling an empty buffer, so it is stable under stall.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({in_valid, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_data;
                else                 tail_d = in_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = in_data;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/renkon_mem_net_burst.sv
// rtl/renkon_mem_net_burst.sv - banked net-parameter memory with burst line reader
module renkon_mem_net_burst
    import renkon_mem_net_pkg::*;
#(
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int NETSIZE  = NETSIZE_DEF,
    parameter int BANKS    = BANKS_DEF,
    parameter int LINESIZE = linesize_of(NETSIZE, BANKS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       host_we,
    input  logic [NETSIZE-1:0]         host_addr,
    input  logic signed [DWIDTH-1:0]   host_wdata,
    input  logic                       burst_start,
    input  logic [LINESIZE-1:0]        burst_base,
    input  logic [LINESIZE:0]          burst_len,
    output logic                       burst_busy,
    output logic                       burst_done,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [BANKS*DWIDTH-1:0]    rd_data
);

    localparam int LB   = lb_of(BANKS);
    localparam int ROWS = 2 ** LINESIZE;
    localparam int CW   = LINESIZE + 1;

    logic signed [DWIDTH-1:0] mem [BANKS][ROWS];

    logic [LINESIZE-1:0]     wr_row;
    logic [BANKS-1:0]        wr_bank_en;
    logic [BANKS*DWIDTH-1:0] rd_line;
    logic [1:0]              skid_count;
    logic [2:0]              occ_after;
    logic                    pop;

    state_t              state_q, state_d;
    logic [LINESIZE-1:0] addr_q, addr_d;
    logic [LINESIZE-1:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0]       remaining_q, remaining_d;
    logic [CW-1:0]       accepted_q, accepted_d;
    logic [CW-1:0]       len_q, len_d;
    logic                issue_q, issue_d;
    logic                zero_done_q, zero_done_d;

    generate
        if (LB == 0) begin : g_one_bank
            assign wr_row     = host_addr;
            assign wr_bank_en = host_we;
        end else begin : g_multi_bank
            assign wr_row     = host_addr[NETSIZE-1:LB];
            assign wr_bank_en = host_we ? (BANKS'(1) << host_addr[LB-1:0]) : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int k = 0; k < BANKS; k++) begin
            if (wr_bank_en[k]) mem[k][wr_row] <= host_wdata;
        end
    end

    // Asynchronous read of the registered line address gives write-first behaviour.
    always_comb begin
        rd_line = '0;
        for (int k = 0; k < BANKS; k++) begin
            rd_line[lane_lsb(k, DWIDTH) +: DWIDTH] = mem[k][rd_addr_q];
        end
    end

    assign pop       = rd_valid && rd_ready;
    assign occ_after = {1'b0, skid_count} + {2'b00, issue_q} - {2'b00, pop};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        accepted_d  = accepted_q;
        len_d       = len_q;
        issue_d     = 1'b0;
        zero_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (burst_start) begin
                    if (burst_len == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        addr_d      = burst_base;
                        remaining_d = burst_len;
                        accepted_d  = '0;
                        len_d       = burst_len;
                    end
                end
            end
            ST_RUN: begin
                // Never let buffered plus in-flight lines exceed the two skid slots.
                if (remaining_q != '0 && occ_after < 3'd2) begin
                    issue_d     = 1'b1;
                    rd_addr_d   = addr_q;
                    addr_d      = addr_q + LINESIZE'(1);
                    remaining_d = remaining_q - CW'(1);
                end
                if (pop) begin
                    accepted_d = accepted_q + CW'(1);
                    if (accepted_d == len_q) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            accepted_q  <= '0;
            len_q       <= '0;
            issue_q     <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            accepted_q  <= accepted_d;
            len_q       <= len_d;
            issue_q     <= issue_d;
            zero_done_q <= zero_done_d;
        end
    end

    assign burst_busy = (state_q == ST_RUN);
    assign burst_done = (state_q == ST_DONE) || zero_done_q;

    renkon_mem_net_skid #(
        .WIDTH (BANKS * DWIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue_q),
        .in_data   (rd_line),
        .out_valid (rd_valid),
        .out_ready (rd_ready),
        .out_data  (rd_data),
        .count     (skid_count)
    );

endmodule

// File: tb/tb_renkon_mem_net_burst.sv
// tb/tb_renkon_mem_net_burst.sv - self-checking bench for the banked burst net memory
module tb_renkon_mem_net_burst;

    localparam int NLINES = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_we;
    logic [13:0] host_addr;
    logic [15:0] host_wdata;
    logic        burst_start;
    logic [11:0] burst_base;
    logic [12:0] burst_len;
    logic        burst_busy;
    logic        burst_done;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_data;

    renkon_mem_net_burst dut (
        .clk         (clk),
        .rst         (rst),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .burst_start (burst_start),
        .burst_base  (burst_base),
        .burst_len   (burst_len),
        .burst_busy  (burst_busy),
        .burst_done  (burst_done),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int base;
        int len;
        int mode;
        int exp_first;
        int exp_last;
        int exp_done;
    } vec_t;

    vec_t        vecs [5];
    logic [15:0] model [0:16383];
    logic [63:0] exp_q [$];

    int          n_vec = 0;
    int          n_err = 0;
    int          beats, done_cnt, first_k, last_pop_k, done_k;
    logic        busy_seen, stalled_prev;
    logic [63:0] held;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] line_of(input int line);
        logic [63:0] v;
        for (int k = 0; k < 4; k++) v[k*16 +: 16] = model[line*4 + k];
        return v;
    endfunction

    function automatic logic pat(input int mode, input int k);
        return (mode == 0) ? 1'b1 : ((k % 3) == 0);
    endfunction

    task automatic reset_stats();
        beats = 0; done_cnt = 0; first_k = -1; last_pop_k = -1; done_k = -1;
        busy_seen = 1'b0; stalled_prev = 1'b0; held = '0;
        exp_q.delete();
    endtask

    task automatic sample(input int k);
        if (rd_valid && first_k < 0) first_k = k;
        if (stalled_prev) begin
            chk("stall_hold_data", rd_data, held);
            chk("stall_hold_valid", rd_valid, 1);
        end
        if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else                   chk("beat_data", rd_data, exp_q.pop_front());
            beats++;
            last_pop_k = k;
        end
        if (burst_done) begin
            done_cnt++;
            done_k = k;
        end
        if (burst_busy) busy_seen = 1'b1;
        stalled_prev = rd_valid && !rd_ready;
        held = rd_data;
    endtask

    task automatic host_write(input int a, input logic [15:0] d);
        host_we = 1'b1; host_addr = 14'(a); host_wdata = d;
        model[a] = d;
        @(posedge clk); #1;
        host_we = 1'b0;
    endtask

    // Mode 1 also re-asserts burst_start mid-burst, which must be ignored.
    task automatic run_burst(input int base, input int len, input int mode,
                             input int wr_k, input int wr_a, input logic [15:0] wr_d);
        reset_stats();
        if (wr_k >= 0) model[wr_a] = wr_d;
        for (int i = 0; i < len; i++) exp_q.push_back(line_of((base + i) % NLINES));
        burst_start = 1'b1; burst_base = 12'(base); burst_len = 13'(len);
        @(posedge clk); #1;
        burst_start = 1'b0;
        rd_ready    = pat(mode, 0);
        host_we     = (wr_k == 0);
        host_addr   = 14'(wr_a); host_wdata = wr_d;
        for (int k = 0; k < len * 3 + 8; k++) begin
            @(negedge clk);
            sample(k);
            @(posedge clk); #1;
            rd_ready    = pat(mode, k + 1);
            host_we     = (wr_k == k + 1);
            burst_start = (mode == 1) && (k + 1 == 4);
        end
        burst_start = 1'b0;
        host_we     = 1'b0;
    endtask

    task automatic check_burst(input vec_t v);
        chk("beat_count", beats, v.len);
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_k, v.exp_done);
        chk("first_valid_cycle", first_k, v.exp_first);
        chk("last_accept_cycle", last_pop_k, v.exp_last);
        chk("busy_seen", busy_seen, (v.len > 0) ? 1 : 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{base: 0,    len: 4, mode: 0, exp_first: 2,  exp_last: 5,  exp_done: 6};
        vecs[1] = '{base: 0,    len: 4, mode: 1, exp_first: 2,  exp_last: 12, exp_done: 13};
        vecs[2] = '{base: 0,    len: 0, mode: 0, exp_first: -1, exp_last: -1, exp_done: 0};
        vecs[3] = '{base: 4095, len: 2, mode: 0, exp_first: 2,  exp_last: 3,  exp_done: 4};
        vecs[4] = '{base: 1,    len: 3, mode: 1, exp_first: 2,  exp_last: 9,  exp_done: 10};

        rst = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        burst_start = 1'b0; burst_base = '0; burst_len = '0; rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", burst_busy, 0);
        chk("reset_done", burst_done, 0);
        chk("reset_valid", rd_valid, 0);
        chk("reset_data", rd_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int a = 0; a < 16; a++) host_write(a, 16'(100 + a));
        for (int i = 0; i < 4; i++) host_write(16380 + i, 16'(-100 - i));

        for (int v = 0; v < 5; v++) begin
            run_burst(vecs[v].base, vecs[v].len, vecs[v].mode, -1, 0, 16'd0);
            check_burst(vecs[v]);
        end

        // Write word 5 on the same edge that line 1 is issued.
        run_burst(0, 4, 0, 1, 5, 16'(-7));
        check_burst(vecs[0]);

        // Reset during the second beat of an 8-line burst.
        reset_stats();
        for (int i = 0; i < 8; i++) exp_q.push_back(line_of(i));
        burst_start = 1'b1; burst_base = 12'd0; burst_len = 13'd8;
        @(posedge clk); #1;
        burst_start = 1'b0; rd_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 4) chk("valid_after_reset", rd_valid, 0);
            sample(k);
            @(posedge clk); #1;
            rst = (k + 1 == 3);
        end
        rst = 1'b0;
        chk("reset_beats", beats, 2);
        chk("reset_no_done", done_cnt, 0);
        run_burst(2, 2, 0, -1, 0, 16'd0);
        check_burst('{base: 2, len: 2, mode: 0, exp_first: 2, exp_last: 3, exp_done: 4});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
